// File: rtl/elevator_call_scheduler_if.sv
// Button/controller-facing signal bundle for elevator_call_scheduler.
// The scheduler uses the slave modport; whoever drives the buttons and floor uses master.
`timescale 1ns/1ps
interface elevator_call_scheduler_if;
    logic [3:0] call_btn;
    logic [3:0] present_floor;
    logic [3:0] requested_floor;
    logic [3:0] pending;
    logic       door_open;
    logic       dir_up;
    logic       busy;

    modport master (
        output call_btn, present_floor,
        input  requested_floor, pending, door_open, dir_up, busy
    );

    modport slave (
        input  call_btn, present_floor,
        output requested_floor, pending, door_open, dir_up, busy
    );
endinterface

// File: rtl/elevator_call_scheduler.sv
// Four-floor collective (SCAN) call scheduler with door dwell; one-hot floors throughout.
// Define ELEV_CALL_SYNC_EN to put a 2-flop synchronizer in front of button edge detection.
`timescale 1ns/1ps
module elevator_call_scheduler #(
    parameter int unsigned DWELL_CYCLES = 8
) (
    input logic                      clk,
    input logic                      reset,
    elevator_call_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, UP, DOWN, DWELL} state_t;

    localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES - 1);

    state_t     state, state_n;
    logic [3:0] pending_q, pending_n;
    logic [3:0] req_q, req_n;
    logic [3:0] dwell_floor, dwell_floor_n;
    logic [3:0] btn_s, btn_prev, captured, clear, eval_p, above, below;
    logic [7:0] cnt, cnt_n;
    logic [1:0] cur;
    logic       dir_q, dir_n, door_q, busy_q;
    logic       floor_valid, expire, prefer_up;

`ifdef ELEV_CALL_SYNC_EN
    logic [3:0] sync_a, sync_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= bus.call_btn;
            sync_b <= sync_a;
        end
    end
    assign btn_s = sync_b;
`else
    assign btn_s = bus.call_btn;
`endif

    assign floor_valid = (bus.present_floor != 4'd0) &&
                         ((bus.present_floor & (bus.present_floor - 4'd1)) == 4'd0);

    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    always_comb begin
        cur = 2'd0;
        for (int i = 0; i < 4; i++)
            if (bus.present_floor[i]) cur = 2'(i);
    end

    // A dwell that expires this cycle must not re-serve its own floor.
    assign expire    = (state == DWELL) && (cnt == 8'd0);
    assign eval_p    = expire ? (pending_q & ~dwell_floor) : pending_q;
    assign prefer_up = (state == IDLE) || dir_q;

    // Scanning high-to-low leaves the lowest hit above; low-to-high leaves the highest below.
    always_comb begin
        above = '0;
        below = '0;
        for (int i = 3; i >= 0; i--)
            if (eval_p[i] && (i > int'(cur))) above = 4'b0001 << i;
        for (int i = 0; i < 4; i++)
            if (eval_p[i] && (i < int'(cur))) below = 4'b0001 << i;
    end

    always_comb begin
        captured = btn_s & ~btn_prev;
        if (state == DWELL) captured = captured & ~dwell_floor;
        clear     = (floor_valid && expire) ? dwell_floor : 4'd0;
        pending_n = (pending_q | captured) & ~clear;

        state_n       = state;
        req_n         = req_q;
        dir_n         = dir_q;
        cnt_n         = cnt;
        dwell_floor_n = dwell_floor;

        if (floor_valid) begin
            if ((state == DWELL) && !expire) begin
                cnt_n = cnt - 8'd1;
            end else if ((eval_p & bus.present_floor) != 4'd0) begin
                state_n       = DWELL;
                req_n         = bus.present_floor;
                cnt_n         = DWELL_LOAD;
                dwell_floor_n = bus.present_floor;
            end else if (prefer_up && (above != 4'd0)) begin
                state_n = UP;
                req_n   = above;
                dir_n   = 1'b1;
            end else if (below != 4'd0) begin
                state_n = DOWN;
                req_n   = below;
                dir_n   = 1'b0;
            end else if (above != 4'd0) begin
                state_n = UP;
                req_n   = above;
                dir_n   = 1'b1;
            end else begin
                state_n = IDLE;
                req_n   = bus.present_floor;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pending_q   <= '0;
            req_q       <= 4'b0001;
            dir_q       <= 1'b1;
            door_q      <= 1'b0;
            busy_q      <= 1'b0;
            cnt         <= '0;
            dwell_floor <= '0;
            btn_prev    <= '0;
        end else begin
            state       <= state_n;
            pending_q   <= pending_n;
            req_q       <= req_n;
            dir_q       <= dir_n;
            door_q      <= (state_n == DWELL);
            busy_q      <= (state_n != IDLE);
            cnt         <= cnt_n;
            dwell_floor <= dwell_floor_n;
            btn_prev    <= btn_s;
        end
    end

    assign bus.requested_floor = req_q;
    assign bus.pending         = pending_q;
    assign bus.door_open       = door_q;
    assign bus.dir_up          = dir_q;
    assign bus.busy            = busy_q;
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench for elevator_call_scheduler: vector table, directed corner cases,
// and randomized traffic against a floor-index reference model.
`timescale 1ns/1ps
module tb_elevator_call_scheduler;
    localparam int DWELL = 8;
`ifdef ELEV_CALL_SYNC_EN
    localparam int SYNC_LAT = 3;
`else
    localparam int SYNC_LAT = 1;
`endif

    typedef struct {
        logic [3:0] btn;
        logic [3:0] pf;
        logic [3:0] pend;
        logic [3:0] req;
        logic       door;
        logic       dir;
        logic       busy;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    elevator_call_scheduler_if bus();
    elevator_call_scheduler #(.DWELL_CYCLES(DWELL)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int passed = 0;
    int total  = 0;
    bit compare_model = 1'b0;

    // Reference model: floors as integer indices, calls as a bitmap.
    bit [3:0] m_pend, m_prev, m_s1, m_s2;
    int       m_target, m_timer, m_dwell;
    bit       m_up, m_moving, m_door;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pend = 0; m_prev = 0; m_s1 = 0; m_s2 = 0;
        m_target = 0; m_timer = 0; m_dwell = 0;
        m_up = 1; m_moving = 0; m_door = 0;
    endtask

    function automatic int floor_of(input bit [3:0] pf);
        if ($countones(pf) != 1) return -1;
        for (int i = 0; i < 4; i++) if (pf[i]) return i;
        return -1;
    endfunction

    task automatic decide(input bit [3:0] p, input int f, input bit pref);
        int up_t = -1;
        int dn_t = -1;
        for (int i = 3; i > f; i--) if (p[i]) up_t = i;
        for (int i = 0; i < f; i++) if (p[i]) dn_t = i;
        if (p[f]) begin
            m_door = 1; m_timer = DWELL - 1; m_dwell = f; m_target = f; m_moving = 0;
        end else if (pref && up_t >= 0) begin
            m_moving = 1; m_up = 1; m_target = up_t;
        end else if (dn_t >= 0) begin
            m_moving = 1; m_up = 0; m_target = dn_t;
        end else if (up_t >= 0) begin
            m_moving = 1; m_up = 1; m_target = up_t;
        end else begin
            m_moving = 0; m_target = f;
        end
    endtask

    task automatic model_step(input bit [3:0] btn, input bit [3:0] pf);
        int       f    = floor_of(pf);
        bit [3:0] seen = (SYNC_LAT == 3) ? m_s2 : btn;
        bit [3:0] rise = seen & ~m_prev;
        bit [3:0] clr  = 0;
        bit [3:0] p;
        bit       pref;
        if (m_door) rise[m_dwell] = 1'b0;
        if (f >= 0) begin
            if (m_door && m_timer > 0) begin
                m_timer--;
            end else begin
                pref = m_door ? m_up : (m_moving ? m_up : 1'b1);
                p = m_pend;
                if (m_door) begin
                    clr[m_dwell] = 1'b1;
                    p[m_dwell]   = 1'b0;
                end
                m_door = 0;
                decide(p, f, pref);
            end
        end
        m_pend = (m_pend | rise) & ~clr;
        m_prev = seen;
        m_s2   = m_s1;
        m_s1   = btn;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_pend"}, 8'(bus.pending), 8'(m_pend));
        check({tag, "_req"}, 8'(bus.requested_floor), 8'(4'b0001 << m_target));
        check({tag, "_door"}, 8'(bus.door_open), 8'(m_door));
        check({tag, "_dir"}, 8'(bus.dir_up), 8'(m_up));
        check({tag, "_busy"}, 8'(bus.busy), 8'(m_moving | m_door));
    endtask

    // One clock: model consumes the inputs the DUT is about to sample; outputs read at negedge.
    task automatic cycle();
        model_step(bus.call_btn, bus.present_floor);
        @(posedge clk);
        @(negedge clk);
        if (compare_model) compare_all("rand");
    endtask

    task automatic press(input logic [3:0] mask);
        bus.call_btn = bus.call_btn | mask;
        repeat (SYNC_LAT) cycle();
        bus.call_btn = bus.call_btn & ~mask;
    endtask

    task automatic apply_reset();
        bus.call_btn      = 4'd0;
        bus.present_floor = 4'b0001;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_door(output int n);
        n = 0;
        while (bus.door_open && n < 40) begin
            n++;
            cycle();
        end
    endtask

    vec_t tbl[13];
    int   n;
    int   hold;

    initial begin
        tbl[0] = '{4'h0, 4'h1, 4'h0, 4'h1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{4'h8, 4'h1, 4'h8, 4'h1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{4'h0, 4'h1, 4'h8, 4'h8, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{4'h0, 4'h2, 4'h8, 4'h8, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{4'h0, 4'h8, 4'h8, 4'h8, 1'b1, 1'b1, 1'b1};
        for (int i = 5; i < 12; i++) tbl[i] = '{4'h0, 4'h8, 4'h8, 4'h8, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{4'h0, 4'h8, 4'h0, 4'h8, 1'b0, 1'b1, 1'b0};

        apply_reset();
        check("rst_pend", 8'(bus.pending), 8'h0);
        check("rst_req", 8'(bus.requested_floor), 8'h1);
        check("rst_door", 8'(bus.door_open), 8'h0);
        check("rst_dir", 8'(bus.dir_up), 8'h1);
        check("rst_busy", 8'(bus.busy), 8'h0);

        // Single call to floor 3, travel, full dwell, clear.
        for (int i = 0; i < 13; i++) begin
            if (i == 1) begin
                bus.call_btn = tbl[1].btn;
                repeat (SYNC_LAT - 1) cycle();
            end
            bus.call_btn      = tbl[i].btn;
            bus.present_floor = tbl[i].pf;
            cycle();
            check($sformatf("vec%0d_pend", i), 8'(bus.pending), 8'(tbl[i].pend));
            check($sformatf("vec%0d_req", i), 8'(bus.requested_floor), 8'(tbl[i].req));
            check($sformatf("vec%0d_door", i), 8'(bus.door_open), 8'(tbl[i].door));
            check($sformatf("vec%0d_dir", i), 8'(bus.dir_up), 8'(tbl[i].dir));
            check($sformatf("vec%0d_busy", i), 8'(bus.busy), 8'(tbl[i].busy));
        end

        // Asynchronous reset while calls are pending.
        bus.present_floor = 4'b0001;
        cycle();
        press(4'b1010);
        cycle();
        check("mid_pend_before", 8'(bus.pending), 8'hA);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_pend", 8'(bus.pending), 8'h0);
        check("mid_rst_req", 8'(bus.requested_floor), 8'h1);
        check("mid_rst_door", 8'(bus.door_open), 8'h0);
        check("mid_rst_dir", 8'(bus.dir_up), 8'h1);
        check("mid_rst_busy", 8'(bus.busy), 8'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // SCAN order: heading up from floor 1, floors 0 and 2 pressed on the way.
        bus.present_floor = 4'b0010;
        cycle();
        press(4'b1000);
        cycle();
        check("scan_first_req", 8'(bus.requested_floor), 8'h8);
        press(4'b0101);
        cycle();
        check("scan_preempt_req", 8'(bus.requested_floor), 8'h4);
        bus.present_floor = 4'b0100;
        cycle();
        check("scan_door_f2", 8'(bus.door_open), 8'h1);
        wait_door(n);
        check("scan_dwell_len", 8'(n), 8'(DWELL));
        check("scan_next_req", 8'(bus.requested_floor), 8'h8);
        check("scan_after_f2_pend", 8'(bus.pending), 8'h9);
        bus.present_floor = 4'b1000;
        cycle();
        wait_door(n);
        check("scan_rev_req", 8'(bus.requested_floor), 8'h1);
        check("scan_rev_dir", 8'(bus.dir_up), 8'h0);
        check("scan_rev_pend", 8'(bus.pending), 8'h1);

        // Call at the current floor goes straight to dwell; a re-press there is ignored.
        apply_reset();
        bus.present_floor = 4'b0100;
        cycle();
        check("here_idle_req", 8'(bus.requested_floor), 8'h4);
        press(4'b0100);
        cycle();
        check("here_door", 8'(bus.door_open), 8'h1);
        check("here_req", 8'(bus.requested_floor), 8'h4);
        press(4'b0100);
        wait_door(n);
        check("here_pend_after", 8'(bus.pending), 8'h0);
        check("here_busy_after", 8'(bus.busy), 8'h0);

        // Non-one-hot floor freezes the scheduler but not capture.
        apply_reset();
        cycle();
        press(4'b0100);
        cycle();
        bus.present_floor = 4'b0110;
        repeat (3) cycle();
        check("inv_req", 8'(bus.requested_floor), 8'h4);
        check("inv_pend", 8'(bus.pending), 8'h4);
        check("inv_door", 8'(bus.door_open), 8'h0);
        check("inv_busy", 8'(bus.busy), 8'h1);
        bus.present_floor = 4'b0100;
        cycle();
        check("inv_recover_door", 8'(bus.door_open), 8'h1);

        // Capture latency from a button step to pending.
        apply_reset();
        cycle();
        bus.call_btn = 4'b0010;
        n = 0;
        while (!bus.pending[1] && n < 10) begin
            cycle();
            n++;
        end
        check("sync_latency", 8'(n), 8'(SYNC_LAT));
        bus.call_btn = 4'b0000;

        // Randomized traffic against the reference model.
        apply_reset();
        compare_model = 1'b1;
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) bus.call_btn[b] = ~bus.call_btn[b];
            if (hold == 0) begin
                if ($urandom_range(0, 7) == 0) bus.present_floor = 4'($urandom_range(0, 15)) | 4'b0110;
                else bus.present_floor = 4'b0001 << $urandom_range(0, 3);
                hold = $urandom_range(1, 6);
            end
            hold--;
            cycle();
        end
        compare_model = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Request-side companion to the floor-stepping elevator controller. Latches per-floor call buttons, runs a collective (SCAN) scheduling policy against the controller's `present_floor`, and drives the one-hot `requested_floor` target the controller steps toward. Also holds a door-dwell interval at each served floor and then clears that call. It sits between the button inputs and the controller's request input, four floors, one-hot encoding throughout.

## Interface
- `DWELL_CYCLES`, default 8: cycles `door_open` stays high at a served floor. Legal range is 1..255; the counter is 8 bits.

- `clk`  in  1  system clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `call_btn`  in  4  raw call buttons, bit i = floor i; level, may be asynchronous
- `present_floor`  in  4  one-hot current floor from controller (0001 = floor 0 … 1000 = floor 3)
- `requested_floor`  out  4  registered one-hot target for controller
- `pending`  out  4  registered latched-call bitmap
- `door_open`  out  1  high while in DWELL
- `dir_up`  out  1  current sweep direction (1 = up, 0 = down)
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- **Reset values:** `requested_floor` = 0001, `pending` = 0000, `door_open` = 0, `dir_up` = 1, `busy` = 0, state = IDLE, dwell counter = 0.
- **Call capture:** a rising edge on `call_btn[i]` (current sample 1, previous sample 0) sets `pending[i]`. Holding a button sets the bit once.
  - Exception: an edge on the floor currently in DWELL is ignored.
  - Other floors' edges during DWELL are captured normally.
- **Valid floor:** `present_floor` is valid only if it is one-hot. When it is invalid, the block does not change state, does not clear calls, and holds `requested_floor`. Call capture continues.
- **"Above" and "below":** measured against the current floor index.
- **IDLE** (pending = 0): `requested_floor` = `present_floor`. When `pending` becomes nonzero:
  - If the pending bit at the current floor is set, go to DWELL.
  - Else if any call is above, go to UP with `dir_up` = 1.
  - Else go to DOWN with `dir_up` = 0.
- **UP:** target = lowest pending floor above the current floor.
  - If none is above but some are below, go to DOWN and target the highest pending floor below.
  - If `pending[current]` is set, go to DWELL.
- **DOWN:** mirror of UP. Target = highest pending floor below; reverse to UP when none remain below.
- **Target re-evaluation:** the target is recomputed every cycle. A new call between the current floor and the target, in the sweep direction, preempts the target.
- **DWELL:**
  - On entry, `door_open` = 1 and the counter loads `DWELL_CYCLES`−1.
  - The counter decrements each cycle.
  - At 0, clear `pending[current]`, drop `door_open`, and re-evaluate as in IDLE, preferring the current `dir_up` direction.
- **Reset mid-operation:** all pending calls are dropped immediately (asynchronous). Outputs return to their reset values.

## Timing
- **Capture latency:** `pending[i]` goes high 1 clock after the first edge that samples `call_btn[i]` = 1 (base build). Add 2 clocks with the synchronizer.
- **Output latency:** `requested_floor`, `dir_up` and `busy` reflect a `pending` or `present_floor` change 1 clock later. All outputs are registered.
- **Arrival to door:** `door_open` rises 1 clock after `present_floor` matches a pending floor.
- **Dwell:** `door_open` is high for exactly `DWELL_CYCLES` cycles. `pending[i]` clears on the same edge that `door_open` falls.
- **Simultaneous edges:** when a button edge and the DWELL-expiry clear hit the same floor on the same edge, the clear wins.
- **Controller rate:** the controller may step at any rate. This block needs no handshake beyond `present_floor` stability for 1 cycle.

## Configuration
- **Macro:** `ELEV_CALL_SYNC_EN`.
- **Defined:** `call_btn` passes through a 2-flop synchronizer per bit before edge detection. Capture latency is 3 clocks.
- **Undefined:** edge detection samples `call_btn` directly with a single history flop. Capture latency is 1 clock, and inputs must already be synchronous to `clk`.
- **Unaffected:** all other behaviour is identical in both builds.

## Test plan
- **Reset values:** assert `reset` mid-run with pending = 1010 → same cycle `pending` = 0000, `requested_floor` = 0001, `door_open` = 0, `dir_up` = 1, `busy` = 0.
- **Single call:** `present_floor` = 0001, pulse `call_btn[3]` → `pending` = 1000, `requested_floor` = 1000, `dir_up` = 1. Then drive `present_floor` = 1000 → `door_open` high for 8 cycles, then `pending` = 0000, `busy` = 0.
- **SCAN order:** `present_floor` = 0010 heading up to floor 3; press floors 0 and 2 → `requested_floor` = 0100, then 1000 after floor 2 dwell, then 0001 with `dir_up` = 0.
- **Call at current floor:** IDLE at 0100, press `call_btn[2]` → DWELL directly, `requested_floor` stays 0100. Re-pressing `call_btn[2]` during DWELL leaves `pending` = 0000 after expiry.
- **Invalid floor:** `present_floor` = 0110 with pending = 0100 → no clear, no state change, `requested_floor` held.
- **Sync latency:** in both macro builds, step `call_btn[1]` and count clocks → 1 clock (undefined) and 3 clocks (defined) to `pending[1]`.
